// File: rtl/keccak_pkg.sv
// Shared definitions for the slice-serial Keccak theta stage.
// Optional build macro: KECCAK_THETA_BYPASS_EN (pass-through mode port).
package keccak_pkg;
  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int ADDR_W  = 6;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  // Column parity of one slice: bit x = XOR over y of bit (x + 5*y)
  function automatic logic [4:0] col_parity(input logic [SLICE_W-1:0] s);
    logic [4:0] c;
    c = '0;
    for (int x = 0; x < 5; x++)
      c[x] = s[x] ^ s[x+5] ^ s[x+10] ^ s[x+15] ^ s[x+20];
    return c;
  endfunction
endpackage

// File: rtl/keccak_theta_slice.sv
// Combinational theta for one slice given the previous slice's column parity.
module keccak_theta_slice
  import keccak_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  input  logic [4:0]         prev_c,
  output logic [SLICE_W-1:0] slice_out,
  output logic [4:0]         cur_c
);
  logic [4:0] d;

  assign cur_c = col_parity(slice);

  genvar x, y;
  generate
    for (x = 0; x < 5; x++) begin : g_col
      // Left neighbour column in this slice, right neighbour column one slice back
      assign d[x] = cur_c[(x+4)%5] ^ prev_c[(x+1)%5];
      for (y = 0; y < 5; y++) begin : g_row
        assign slice_out[x+5*y] = slice[x+5*y] ^ d[x];
      end
    end
  endgenerate
endmodule

// File: rtl/keccak_theta.sv
// Slice-serial theta: primes parity from slice 63, then streams slices 0..63
// with a two-slice read-to-write lag. Optional macro KECCAK_THETA_BYPASS_EN
// adds a bypass input that forwards slices untouched with identical timing.
module keccak_theta
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [SLICE_W-1:0] slice_in,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [SLICE_W-1:0] slice_out,
  output logic               busy,
  output logic               done
`ifdef KECCAK_THETA_BYPASS_EN
  ,
  input  logic               bypass
`endif
);
  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic                prime_d;
  logic [1:0]          vld_pipe;   // [0]: slice_in holds a streamed slice, [1]: output valid
  logic [ADDR_W-1:0]   addr_d;
  logic [4:0]          prev_c;
  logic [4:0]          cur_c;
  logic [SLICE_W-1:0]  theta_out;
  logic                byp_q;

  keccak_theta_slice u_slice (
    .slice     (slice_in),
    .prev_c    (prev_c),
    .slice_out (theta_out),
    .cur_c     (cur_c)
  );

`ifdef KECCAK_THETA_BYPASS_EN
  // Bypass mode is captured once per pass, alongside the accepted start
  always_ff @(posedge clk) begin
    if (rst)                         byp_q <= 1'b0;
    else if (state == IDLE && start) byp_q <= bypass;
  end
`else
  assign byp_q = 1'b0;
`endif

  // Next-state and read-port decode
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_addr  = '0;
    case (state)
      IDLE:  if (start) state_nx = PRIME;
      PRIME: begin
        rd_en    = 1'b1;
        rd_addr  = ADDR_W'(DEPTH-1);
        state_nx = RUN;
      end
      RUN: begin
        rd_en   = 1'b1;
        rd_addr = cnt;
        if (cnt == ADDR_W'(DEPTH-1)) state_nx = DRAIN;
      end
      DRAIN: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, read counter and the read-data / write pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prime_d   <= 1'b0;
      vld_pipe  <= '0;
      addr_d    <= '0;
      prev_c    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      slice_out <= '0;
      done      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= (state == RUN) ? cnt + 1'b1 : '0;
      prime_d     <= (state == PRIME);
      vld_pipe[0] <= (state == RUN);
      vld_pipe[1] <= vld_pipe[0];
      addr_d      <= rd_addr;
      if (prime_d || vld_pipe[0]) prev_c <= cur_c;
      wr_en       <= vld_pipe[0];
      if (vld_pipe[0]) begin
        wr_addr   <= addr_d;
        slice_out <= byp_q ? slice_in : theta_out;
      end
      // Last write is on the bus and nothing follows it
      done <= (state == DRAIN) && vld_pipe[1] && !vld_pipe[0];
    end
  end

  // Busy drops in the done cycle even though the FSM leaves DRAIN one cycle later
  assign busy = (state != IDLE) && !done;
endmodule

// File: doc/keccak_theta.md
# keccak_theta

Theta step of the slice-serial Keccak-f[1600] permutation; sits directly upstream of the rho/pi rotate stage. It streams the 64 slices (25 bits each) of the state from the slice memory and computes column parities on the fly. Each transformed slice is emitted with a write strobe and address for the next stage. It processes one slice per cycle with a 1-slice parity lookback, including the z=0 wrap to slice 63.

## Interface
- SLICE_W, 25, bits per slice; bit index = x + 5*y, with x, y in 0..4.
- DEPTH, 64, slices per state (lane length); address width is 6.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one theta pass; sampled only in IDLE.
- rd_en  out  1  slice read request to the synchronous-read state memory.
- rd_addr  out  6  slice index being read.
- slice_in  in  25  read data; valid the cycle after rd_en.
- wr_en  out  1  output slice valid/write strobe to the rotate stage.
- wr_addr  out  6  z index of slice_out.
- slice_out  out  25  theta-transformed slice.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse after the last write.
- bypass  in  1  present only with KECCAK_THETA_BYPASS_EN.

## Operation
- C[x][z] = XOR over y of A[x+5y][z].
- D[x][z] = C[(x+4)%5][z] ^ C[(x+1)%5][(z+63)%64].
- A'[x+5y][z] = A[x+5y][z] ^ D[x][z].
- FSM has four states:
  - IDLE: start=1 moves to PRIME.
  - PRIME: reads addr 63; moves to RUN.
  - RUN: reads addr 0..63, one per cycle.
  - DRAIN: finishes the pipeline, pulses done, returns to IDLE.
- prev_c (5 bits) holds C of the previous slice.
  - It is loaded from slice 63 during priming.
  - It is updated with each streamed slice.
- The first read of slice 63 is used only for parity; it produces no write.
- In-place use is safe. Writes lag reads by 2 slices, and slice 63 is re-read (cycle 64) before it is written (cycle 66).
- start while busy is ignored. A start on the same cycle done pulses is ignored; the block is not yet in IDLE.
- rst in any state: next cycle the block is in IDLE with prev_c=0. A pass in flight is abandoned; no further writes and no done pulse.
- Reset values: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, slice_out=0, busy=0, done=0.

## Timing
- Cycle 0 is the first cycle after the edge at which start is sampled in IDLE.
- rd_en is high in cycles 0..64.
  - Cycle 0: rd_addr=63.
  - Cycle k+1: rd_addr=k, for k=0..63.
- slice_in for the read in cycle n is valid in cycle n+1.
- wr_en is high in cycles 3..66, with wr_addr=k and slice_out=A'[k] in cycle k+3. slice_out is registered.
- done=1 in cycle 67 only. busy=1 in cycles 0..66.
- Start-to-done latency is 68 cycles. Back-to-back passes need start in or after cycle 68.
- No backpressure: downstream must accept one slice per cycle while wr_en=1.

## Configuration
- Macro: KECCAK_THETA_BYPASS_EN.
- Defined:
  - The bypass port exists and is sampled together with start.
  - If bypass was 1 at start, slice_out=slice_in for every slice, with identical timing and strobes.
  - This supports isolated testing of downstream stages.
- Undefined: the port is absent and theta is always applied.

## Structure
- Shared package keccak_pkg holds:
  - constants SLICE_W=25, DEPTH=64, ADDR_W=6;
  - the FSM state enum (IDLE, PRIME, RUN, DRAIN);
  - function col_parity(slice) returning 5 bits.
- One sub-module: keccak_theta_slice. It is combinational and maps (slice, prev_c) to (slice_out, cur_c).

## Test plan
- All-zero state, start -> 64 writes of 0x0000000 with wr_addr 0..63 in cycles 3..66, then done in cycle 67.
- Only slice 0 bit 0 set ->
  - wr_addr 0 outputs 0x0210843;
  - wr_addr 1 outputs 0x1084210;
  - all others 0.
- Only slice 63 bit 0 set (wrap case) ->
  - wr_addr 0 outputs 0x1084210;
  - wr_addr 63 outputs 0x0210843;
  - all others 0.
- Assert rst in cycle 30 of a pass -> wr_en=0, busy=0, done never pulses; a new start then produces a full correct 68-cycle pass.
- Pulse start again at cycles 10 and 67 of a pass -> ignored; exactly 64 writes and one done.
- With KECCAK_THETA_BYPASS_EN and bypass=1, random state -> each slice_out equals the stored slice; same cycles as the theta pass.
